// File: rtl/edf_irq_sched.sv
// Earliest-deadline-first interrupt scheduler with a lane-parallel comparator sweep.
// Define EDF_IRQ_SCHED_MISS_EN to build the sticky deadline-miss flags on miss_o.
module edf_irq_sched #(
  parameter int unsigned NrIrqs  = 8,
  parameter int unsigned NrLanes = 2,
  parameter int unsigned DlWidth = 16,
  localparam int unsigned IdWidth = $clog2(NrIrqs)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrIrqs-1:0]  irq_i,
  input  logic               cfg_we_i,
  input  logic [IdWidth-1:0] cfg_id_i,
  input  logic [DlWidth-1:0] cfg_dl_i,
  output logic               irq_valid_o,
  input  logic               irq_ready_i,
  output logic [IdWidth-1:0] irq_id_o,
  output logic [DlWidth-1:0] irq_dl_o,
  output logic [NrIrqs-1:0]  miss_o
);

  localparam int unsigned Sweep    = NrIrqs / NrLanes;
  localparam int unsigned IdxWidth = (Sweep > 1) ? $clog2(Sweep) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Sweep - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;

  logic [NrIrqs-1:0]   irq_q, trig, pending_q, pending_d;
  logic [DlWidth-1:0]  cnt_q [NrIrqs];
  logic [DlWidth-1:0]  cnt_d [NrIrqs];
  logic [DlWidth-1:0]  rel_dl_q [NrIrqs];
  logic [0:0]          state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic                dirty_q, dirty_d;
  logic                best_found_q;
  logic [IdWidth-1:0]  best_id_q;
  logic [DlWidth-1:0]  best_cnt_q;
  logic                cand_found;
  logic [IdWidth-1:0]  cand_id, k_id;
  logic [DlWidth-1:0]  cand_cnt;
  logic                claim, last, publish;
  logic                valid_q;
  logic [IdWidth-1:0]  id_q;
  logic [DlWidth-1:0]  dl_q;

  assign trig        = irq_i & ~irq_q;
  assign claim       = valid_q & irq_ready_i;
  assign last        = (idx_q == LastIdx);
  assign publish     = (state_q == StScan) && last && !dirty_q && !claim;
  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign irq_dl_o    = dl_q;

  // Pending/countdown update; a trigger colliding with a claim of the same source re-arms it.
  always_comb begin
    for (int unsigned k = 0; k < NrIrqs; k++) begin
      pending_d[k] = pending_q[k];
      cnt_d[k]     = (pending_q[k] && cnt_q[k] != '0) ? cnt_q[k] - 1'b1 : cnt_q[k];
      if (claim && id_q == IdWidth'(k)) pending_d[k] = 1'b0;
      if (trig[k] && (!pending_q[k] || (claim && id_q == IdWidth'(k)))) begin
        pending_d[k] = 1'b1;
        cnt_d[k]     = rel_dl_q[k];
      end
    end
  end

  // Running best is kept decremented so it stays comparable with the live countdowns.
  always_comb begin
    k_id       = '0;
    cand_found = (idx_q == '0) ? 1'b0 : best_found_q;
    cand_id    = (idx_q == '0) ? '0 : best_id_q;
    cand_cnt   = (idx_q == '0) ? '0 : best_cnt_q;
    for (int unsigned l = 0; l < NrLanes; l++) begin
      k_id = IdWidth'(32'(idx_q) * NrLanes + l);
      if (pending_q[k_id] && (!cand_found || cnt_q[k_id] < cand_cnt)) begin
        cand_found = 1'b1;
        cand_id    = k_id;
        cand_cnt   = cnt_q[k_id];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dirty_d = dirty_q;
    case (state_q)
      StIdle: begin
        if (|pending_q) begin
          state_d = StScan;
          idx_d   = '0;
          dirty_d = 1'b0;
        end
      end
      StScan: begin
        if (last) begin
          idx_d   = '0;
          dirty_d = 1'b0;
          state_d = (|pending_q) ? StScan : StIdle;
        end else begin
          idx_d = idx_q + IdxWidth'(1);
          if (claim) dirty_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q        <= '0;
      pending_q    <= '0;
      state_q      <= StIdle;
      idx_q        <= '0;
      dirty_q      <= 1'b0;
      best_found_q <= 1'b0;
      best_id_q    <= '0;
      best_cnt_q   <= '0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      dl_q         <= '0;
      for (int unsigned k = 0; k < NrIrqs; k++) begin
        cnt_q[k]    <= '0;
        rel_dl_q[k] <= '1;
      end
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      for (int unsigned k = 0; k < NrIrqs; k++) cnt_q[k] <= cnt_d[k];
      if (cfg_we_i) rel_dl_q[cfg_id_i] <= cfg_dl_i;
      if (state_q == StScan) begin
        best_found_q <= cand_found;
        best_id_q    <= cand_id;
        best_cnt_q   <= (cand_cnt != '0) ? cand_cnt - 1'b1 : cand_cnt;
      end
      if (publish) begin
        valid_q <= cand_found;
        id_q    <= cand_id;
        dl_q    <= cand_cnt;
      end else if (claim) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef EDF_IRQ_SCHED_MISS_EN
  logic [NrIrqs-1:0] miss_q, miss_d;

  always_comb begin
    for (int unsigned k = 0; k < NrIrqs; k++) begin
      miss_d[k] = miss_q[k] | (pending_q[k] && cnt_q[k] == '0);
      if (claim && id_q == IdWidth'(k)) miss_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) miss_q <= '0;
    else       miss_q <= miss_d;
  end

  assign miss_o = miss_q;
`else
  assign miss_o = '0;
`endif

endmodule

// File: tb/tb_edf_irq_sched.sv
// Directed bench for edf_irq_sched: vector table for ordering plus hand-written corner sequences.
module tb_edf_irq_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_id = '0;
  logic [15:0] cfg_dl = '0;
  logic        ready = 1'b0;
  logic        valid;
  logic [2:0]  id;
  logic [15:0] dl;
  logic [7:0]  miss;

  int checks = 0;
  int errors = 0;

  edf_irq_sched #(.NrIrqs(8), .NrLanes(2), .DlWidth(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_i      (irq),
    .cfg_we_i   (cfg_we),
    .cfg_id_i   (cfg_id),
    .cfg_dl_i   (cfg_dl),
    .irq_valid_o(valid),
    .irq_ready_i(ready),
    .irq_id_o   (id),
    .irq_dl_o   (dl),
    .miss_o     (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id_a;
    int dl_a;
    int id_b;
    int dl_b;
    int exp_first;
    int exp_second;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    irq = '0;
    ready = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int i, input int d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_id = 3'(i);
    cfg_dl = 16'(d);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  // Returns 1 time unit after the trigger edge.
  task automatic trig_pulse(input logic [7:0] mask);
    @(negedge clk);
    irq = irq | mask;
    @(posedge clk);
    #1 irq = irq & ~mask;
  endtask

  task automatic do_claim();
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  ok;
    vecs[0] = '{1, 100, 6, 20, 6, 1};
    vecs[1] = '{2, 50, 5, 50, 2, 5};
    vecs[2] = '{0, 300, 7, 299, 7, 0};
    vecs[3] = '{4, 10, 5, 11, 4, 5};
    vecs[4] = '{3, 0, 6, 5, 3, 6};

    // Reset state and default-deadline first publish
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 32'(valid), 0);
    check("rst_id", 32'(id), 0);
    check("rst_dl", 32'(dl), 0);
    check("rst_miss", 32'(miss), 0);
    trig_pulse(8'h08);
    wait_valid(12, n, ok);
    check("dflt_valid", 32'(ok), 1);
    check("dflt_latency", 32'(n), 5);
    check("dflt_id", 32'(id), 3);
    check("dflt_dl", 32'(dl), 32'hFFFB);

    // EDF ordering table: winner, then the other source after claiming the winner
    for (int v = 0; v < 5; v++) begin
      do_reset();
      cfg_write(vecs[v].id_a, vecs[v].dl_a);
      cfg_write(vecs[v].id_b, vecs[v].dl_b);
      trig_pulse(8'(1 << vecs[v].id_a) | 8'(1 << vecs[v].id_b));
      wait_valid(12, n, ok);
      check($sformatf("v%0d_valid1", v), 32'(ok), 1);
      check($sformatf("v%0d_first", v), 32'(id), 32'(vecs[v].exp_first));
      do_claim();
      check($sformatf("v%0d_claimed", v), 32'(valid), 0);
      wait_valid(8, n, ok);
      check($sformatf("v%0d_valid2", v), 32'(ok), 1);
      check($sformatf("v%0d_second", v), 32'(id), 32'(vecs[v].exp_second));
    end

    // Preemption of an unclaimed winner
    do_reset();
    cfg_write(4, 1000);
    cfg_write(0, 10);
    trig_pulse(8'h10);
    wait_valid(12, n, ok);
    check("pre_valid", 32'(ok), 1);
    check("pre_first", 32'(id), 4);
    trig_pulse(8'h01);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (id == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    check("pre_switch_in_time", 32'(ok), 1);
    check("pre_valid_kept", 32'(valid), 1);

    // Asynchronous reset while sweeping
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("amid_valid", 32'(valid), 0);
    check("amid_id", 32'(id), 0);
    check("amid_dl", 32'(dl), 0);
    check("amid_miss", 32'(miss), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("amid_no_residual", 32'(valid), 0);

    // Claim and trigger of the same source in one cycle
    do_reset();
    cfg_write(3, 1000);
    trig_pulse(8'h08);
    wait_valid(12, n, ok);
    check("coll_valid", 32'(ok), 1);
    check("coll_id", 32'(id), 3);
    repeat (50) @(posedge clk);
    @(negedge clk);
    ready = 1'b1;
    irq[3] = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    irq[3] = 1'b0;
    check("coll_claimed", 32'(valid), 0);
    wait_valid(8, n, ok);
    check("coll_repub", 32'(ok), 1);
    check("coll_repub_id", 32'(id), 3);
    checks++;
    if (dl < 16'd990 || dl > 16'd1000) begin
      errors++;
      $display("FAIL coll_reload: got %0d expected 990..1000", dl);
    end

    // Deadline miss flag
    do_reset();
    cfg_write(7, 3);
    trig_pulse(8'h80);
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      #1;
`ifdef EDF_IRQ_SCHED_MISS_EN
      if (j == 3) check("miss_early", 32'(miss), 0);
      if (j == 4) check("miss_set", 32'(miss), 32'h80);
`else
      if (j == 4) check("miss_absent", 32'(miss), 0);
`endif
    end
    wait_valid(8, n, ok);
    check("miss_valid", 32'(ok), 1);
    check("miss_id", 32'(id), 7);
    check("miss_dl_sat", 32'(dl), 0);
    do_claim();
    check("miss_cleared", 32'(miss), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
